uart_tx_mmio: RTL and testbench

- Memory-mapped serial transmitter that acts as a responder on the CPU external bus (a[15:0], d[7:0], n_oe, n_we).
- Decodes a 2-byte window: DATA at BASE_ADDR, STATUS at BASE_ADDR+1.
- Bytes written to DATA are queued in a small FIFO and shifted out on txd as 8N1 frames, LSB first.
- Sits beside RAM/ROM on the board bus; the CPU polls STATUS to pace its writes.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_mmio_fifo.sv | 65 ++++++
 rtl/uart_tx_mmio.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter.
// Shifter state codes, STATUS bit positions and register offsets.
package uart_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    localparam logic [15:0] OFF_DATA = 16'd0;
    localparam logic [15:0] OFF_STAT = 16'd1;

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Synchronous FIFO holding bytes queued for the UART shifter.
// A push into a full FIFO is accepted when a pop frees a slot that cycle.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             n_clk,
    input  logic             n_rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer and occupancy next-state; pointers wrap by natural overflow.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy registers, cleared by reset.
    always_ff @(posedge n_clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge n_clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Bus-mapped 8N1 UART transmitter: DATA at BASE_ADDR, STATUS at +1.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        n_clk,
    input  logic        n_rst,
    input  logic [15:0] a,
    inout  wire  [7:0]  d,
    input  logic        n_oe,
    input  logic        n_we,
    output logic        txd,
    output logic        busy
);

    localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] CNT_LOAD = 16'(CLKS_PER_BIT - 1);

    logic          sel_data, sel_stat;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic [7:0]    status;
    logic          prev_we_q;
    logic          wr_stb;
    logic          push, pop;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          empty;
    logic          ovf_q, ovf_d;
    logic [2:0]    state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    assign sel_data = (a == BASE_ADDR + OFF_DATA);
    assign sel_stat = (a == BASE_ADDR + OFF_STAT);

    assign empty = (fifo_count == '0);
    assign busy  = (state_q != S_IDLE) | ~empty;

    // STATUS byte assembled from registered state only.
    always_comb begin
        status           = 8'h00;
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = empty;
        status[ST_BUSY]  = busy;
        status[ST_OVF]   = ovf_q;
    end

    assign rd_en   = ~n_oe & n_we & (sel_data | sel_stat);
    assign rd_data = sel_stat ? status : 8'h00;
    assign d       = rd_en ? rd_data : 8'bz;

    assign wr_stb = ~n_we & prev_we_q;
    assign pop    = (state_q == S_IDLE) & ~fifo_empty;
    assign push   = wr_stb & sel_data;

    // Previous write strobe, so a long strobe counts as one write.
    always_ff @(posedge n_clk or negedge n_rst) begin
        if (!n_rst) prev_we_q <= 1'b1;
        else        prev_we_q <= n_we;
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .n_clk   (n_clk),
        .n_rst   (n_rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (d),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Sticky overflow: set on a dropped byte, cleared by STATUS write of bit 3.
    always_comb begin
        ovf_d = ovf_q;
        if (push & fifo_full & ~pop)
            ovf_d = 1'b1;
        else if (wr_stb & sel_stat & d[ST_OVF])
            ovf_d = 1'b0;
    end

    // Shifter next-state: start, 8 data bits LSB first, optional parity, stop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    shift_d = fifo_dout;
                    cnt_d   = CNT_LOAD;
                    state_d = S_START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^fifo_dout;
`endif
                end
            end
            S_START: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = CNT_LOAD;
                    idx_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = CNT_LOAD;
                    shift_d = shift_q >> 1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = CNT_LOAD;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == 16'd0) state_d = S_IDLE;
                else                cnt_d   = cnt_q - 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Shifter and overflow registers; reset aborts any frame in flight.
    always_ff @(posedge n_clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            ovf_q   <= ovf_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Line level decoded from the registered shifter state.
    always_comb begin
        txd = 1'b1;
        unique case (state_q)
            S_START:  txd = 1'b0;
            S_DATA:   txd = shift_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd = par_q;
`endif
            default:  txd = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomised bench for uart_tx_mmio against a frame-level reference model.
// Define UART_TX_PARITY_EN for both RTL and bench to check the parity build.
module tb_uart_tx_mmio;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic        n_clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [15:0] a     = 16'h0000;
    logic [7:0]  d_drv = 8'h00;
    logic        d_en  = 1'b0;
    logic        n_oe  = 1'b1;
    logic        n_we  = 1'b1;
    logic        txd;
    logic        busy;
    wire  [7:0]  d;

    assign d = d_en ? d_drv : 8'bz;

    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (d[i]);
    end

    uart_tx_mmio #(
        .BASE_ADDR    (16'hFF00),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .n_clk (n_clk),
        .n_rst (n_rst),
        .a     (a),
        .d     (d),
        .n_oe  (n_oe),
        .n_we  (n_we),
        .txd   (txd),
        .busy  (busy)
    );

    always #5 n_clk = ~n_clk;

    int vectors = 0;
    int errs    = 0;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: edge index, byte queue and the current frame window.
    int         cyc      = 0;
    int         fr_start = -100;
    int         fr_end   = -10;
    logic [7:0] fr_byte  = 8'h00;
    logic [7:0] q[$];
    bit         m_ovf     = 1'b0;
    bit         m_prev_we = 1'b1;

    always @(posedge n_clk or negedge n_rst) begin
        bit wr, popnow, full0;
        if (!n_rst) begin
            cyc       = 0;
            fr_start  = -100;
            fr_end    = -10;
            q.delete();
            m_ovf     = 1'b0;
            m_prev_we = 1'b1;
        end else begin
            cyc++;
            wr        = !n_we && m_prev_we;
            m_prev_we = n_we;
            full0     = (q.size() == DEPTH);
            popnow    = (cyc > fr_end) && (q.size() != 0);
            if (popnow) begin
                fr_byte  = q.pop_front();
                fr_start = cyc;
                fr_end   = cyc + FRAME;
            end
            if (wr && a == 16'hFF00) begin
                if (!full0 || popnow) q.push_back(d);
                else                  m_ovf = 1'b1;
            end
            if (wr && a == 16'hFF01 && d[3]) m_ovf = 1'b0;
        end
    end

    function automatic logic exp_txd();
        int b;
        if (cyc >= fr_start && cyc < fr_end) begin
            b = (cyc - fr_start) / CPB;
            if (b == 0) return 1'b0;
            if (b <= 8) return fr_byte[b-1];
            if (b == 9 && NBITS == 11) return ^fr_byte;
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy();
        return (cyc < fr_end) || (q.size() != 0);
    endfunction

    function automatic logic [7:0] exp_stat();
        return {4'b0, m_ovf, exp_busy(), q.size() == 0, q.size() == DEPTH};
    endfunction

    always @(negedge n_clk) begin
        chk("txd", {7'b0, txd}, {7'b0, exp_txd()});
        chk("busy", {7'b0, busy}, {7'b0, exp_busy()});
    end

    task automatic rd(input logic [15:0] adr, output logic [7:0] got);
        @(negedge n_clk);
        a    = adr;
        n_oe = 1'b0;
        #1;
        got  = d;
        n_oe = 1'b1;
        a    = 16'h0000;
    endtask

    task automatic wr(input logic [15:0] adr, input logic [7:0] val,
                      input int hold);
        @(negedge n_clk);
        a     = adr;
        d_drv = val;
        d_en  = 1'b1;
        n_we  = 1'b0;
        repeat (hold) @(negedge n_clk);
        n_we  = 1'b1;
        d_en  = 1'b0;
        a     = 16'h0000;
    endtask

    task automatic wait_idle(input int bound);
        bit done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge n_clk);
            if (!busy && !exp_busy()) done = 1'b1;
        end
        if (!done) chk("idle_timeout", {7'b0, busy}, 8'h00);
    endtask

    initial begin
        logic [7:0]  got;
        logic [15:0] ra;
        int          r;

        repeat (3) @(negedge n_clk);
        n_rst = 1'b1;
        rd(16'hFF01, got);
        chk("rst_stat", got, 8'h02);
        rd(16'h1234, got);
        chk("hiz_other", got, 8'hFF);
        rd(16'hFF00, got);
        chk("data_rd", got, 8'h00);

        wr(16'hFF00, 8'hA5, 1);
        wait_idle(200);

        for (int i = 0; i < 6; i++) wr(16'hFF00, 8'(8'h11 * (i + 1)), 1);
        rd(16'hFF01, got);
        chk("ovf_stat", got, exp_stat());
        chk("ovf_const", got, 8'h0D);
        wr(16'hFF01, 8'h08, 1);
        rd(16'hFF01, got);
        chk("clr_stat", got, exp_stat());
        chk("clr_const", got, 8'h05);
        @(negedge n_clk);
        n_oe = 1'b1;
        #1;
        a = 16'hFF01;
        #1;
        chk("hiz_noe", d, 8'hFF);
        a = 16'h0000;
        wait_idle(400);

        wr(16'hFF00, 8'h3C, 5);
        wait_idle(200);

        wr(16'hFF00, 8'h5A, 1);
        wr(16'hFF00, 8'hC3, 1);
        repeat (15) @(negedge n_clk);
        #1;
        n_rst = 1'b0;
        #1;
        chk("rst_txd", {7'b0, txd}, 8'h01);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        repeat (3) @(negedge n_clk);
        n_rst = 1'b1;
        rd(16'hFF01, got);
        chk("post_rst_stat", got, 8'h02);
        repeat (60) @(negedge n_clk);

        for (int it = 0; it < 150; it++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                wr(16'hFF00, 8'($urandom), $urandom_range(1, 3));
            end else if (r < 6) begin
                wr(16'hFF01, 8'($urandom), 1);
            end else if (r < 7) begin
                ra = 16'($urandom);
                if (ra[15:1] == 15'h7F80) ra = 16'h1234;
                wr(ra, 8'($urandom), 1);
            end else if (r < 9) begin
                rd(16'hFF01, got);
                chk("rnd_stat", got, exp_stat());
            end else begin
                repeat ($urandom_range(1, 30)) @(negedge n_clk);
            end
        end
        wait_idle(600);
        rd(16'hFF01, got);
        chk("end_stat", got, exp_stat());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
